pll_lock_sequencer: RTL

- Sequences the fabric PLL: drives the PLL reset input, waits for lock, qualifies lock stability, and releases the downstream system reset only when the PLL is locked.
- Retries a bounded number of times on lock timeout, then parks in a fail state.
- Sits beside the PLL instance, clocked from the raw 50 MHz reference clock, never from a PLL output.

---
 rtl/pll_lock_sequencer.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/pll_lock_sequencer.sv
// PLL bring-up sequencer: pulses the PLL reset, waits for and qualifies lock,
// and holds the PLL-domain system reset until lock has been stable long enough.
module pll_lock_sequencer #(
  parameter int RST_HOLD_CYCLES = 500,
  parameter int LOCK_TIMEOUT    = 50000,
  parameter int LOCK_STABLE     = 1024,
  parameter int MAX_RETRIES     = 3,
  parameter int CNT_W           = 16
) (
  input  logic       refclk,
  input  logic       reset,
  input  logic       pll_lock,
  input  logic       restart,
  output logic       pll_reset,
  output logic       sys_rst,
  output logic       ready,
  output logic       fail,
  output logic       lock_lost,
  output logic [3:0] retry_count
);

  typedef enum logic [2:0] {
    ST_RESET_HOLD,
    ST_WAIT_LOCK,
    ST_STABLE,
    ST_RUN,
    ST_FAIL
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRIES);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_lock_meta;
  logic             r_lock_s;
  logic             r_pll_reset;
  logic             r_sys_rst;
  logic             r_ready;
  logic             r_fail;
  logic             r_lock_lost;
  logic [3:0]       r_retry_count;

  // pll_lock comes from the PLL's own timing domain; bring it onto refclk.
  always_ff @(posedge refclk or posedge reset) begin
    if (reset) begin
      r_lock_meta <= 1'b0;
      r_lock_s    <= 1'b0;
    end else begin
      r_lock_meta <= pll_lock;
      r_lock_s    <= r_lock_meta;
    end
  end

  always_ff @(posedge refclk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_RESET_HOLD;
      r_cnt         <= '0;
      r_pll_reset   <= 1'b1;
      r_sys_rst     <= 1'b1;
      r_ready       <= 1'b0;
      r_fail        <= 1'b0;
      r_lock_lost   <= 1'b0;
      r_retry_count <= 4'd0;
    end else if (restart) begin
      r_state       <= ST_RESET_HOLD;
      r_cnt         <= '0;
      r_pll_reset   <= 1'b1;
      r_sys_rst     <= 1'b1;
      r_ready       <= 1'b0;
      r_fail        <= 1'b0;
      r_lock_lost   <= 1'b0;
      r_retry_count <= 4'd0;
    end else begin
      case (r_state)
        ST_RESET_HOLD: begin
          if (r_cnt == HOLD_LAST) begin
            r_state     <= ST_WAIT_LOCK;
            r_cnt       <= '0;
            r_pll_reset <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        ST_WAIT_LOCK: begin
          if (r_lock_s) begin
            r_state <= ST_STABLE;
            r_cnt   <= '0;
          end else if (r_cnt == TIMEOUT_LAST) begin
            r_cnt       <= '0;
            r_pll_reset <= 1'b1;
            if (r_retry_count == RETRY_LIMIT) begin
              r_state <= ST_FAIL;
              r_fail  <= 1'b1;
            end else begin
              r_state       <= ST_RESET_HOLD;
              r_retry_count <= r_retry_count + 4'd1;
            end
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        ST_STABLE: begin
          // A lock glitch restarts the timeout window without re-pulsing the PLL.
          if (!r_lock_s) begin
            r_state <= ST_WAIT_LOCK;
            r_cnt   <= '0;
          end else if (r_cnt == STABLE_LAST) begin
            r_state   <= ST_RUN;
            r_cnt     <= '0;
            r_sys_rst <= 1'b0;
            r_ready   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        ST_RUN: begin
          if (!r_lock_s) begin
            r_state       <= ST_RESET_HOLD;
            r_cnt         <= '0;
            r_pll_reset   <= 1'b1;
            r_sys_rst     <= 1'b1;
            r_ready       <= 1'b0;
            r_lock_lost   <= 1'b1;
            r_retry_count <= 4'd0;
          end
        end
        ST_FAIL: begin
          r_cnt <= '0;
        end
        default: begin
          r_state     <= ST_RESET_HOLD;
          r_cnt       <= '0;
          r_pll_reset <= 1'b1;
          r_sys_rst   <= 1'b1;
          r_ready     <= 1'b0;
          r_fail      <= 1'b0;
        end
      endcase
    end
  end

  assign pll_reset   = r_pll_reset;
  assign sys_rst     = r_sys_rst;
  assign ready       = r_ready;
  assign fail        = r_fail;
  assign lock_lost   = r_lock_lost;
  assign retry_count = r_retry_count;

endmodule
